// File: rtl/change_dispenser.sv
// Change dispenser: pays out a vend result as a soda pulse followed by
// dime/nickel solenoid pulses, confirming each coin on the drop sensor.
module change_dispenser #(
  parameter int PULSE_CYC   = 2,
  parameter int GAP_CYC     = 1,
  parameter int TIMEOUT_CYC = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_soda,
  input  logic [2:0] i_change,
  input  logic       i_dime_empty,
  input  logic       i_nickle_empty,
  input  logic       i_coin_drop,
  output logic       o_soda_rel,
  output logic       o_dime_rel,
  output logic       o_nickle_rel,
  output logic       o_busy,
  output logic [2:0] o_owed,
  output logic       o_fault,
  output logic       o_lost
);

  localparam int M1   = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int MAXC = (M1 > TIMEOUT_CYC) ? M1 : TIMEOUT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VEND,
    S_SELECT,
    S_RELEASE,
    S_WAIT,
    S_GAP,
    S_FAULT
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    owed, owed_n;
  logic          dime, dime_n;
  logic          lost, lost_n;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      owed  <= '0;
      dime  <= 1'b0;
      lost  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      owed  <= owed_n;
      dime  <= dime_n;
      lost  <= lost_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    owed_n  = owed;
    dime_n  = dime;
    lost_n  = lost | (i_soda && (state != S_IDLE));
    unique case (state)
      S_IDLE: begin
        if (i_soda) begin
          owed_n  = i_change;
          cnt_n   = '0;
          state_n = S_VEND;
        end
      end
      S_VEND: begin
        if (cnt == PULSE_LAST) begin
          cnt_n   = '0;
          state_n = S_SELECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_SELECT: begin
        cnt_n = '0;
        // Dime only when at least two units remain, so owed never wraps
        if (owed == 3'd0) begin
          state_n = S_IDLE;
        end else if (owed >= 3'd2 && !i_dime_empty) begin
          dime_n  = 1'b1;
          state_n = S_RELEASE;
        end else if (!i_nickle_empty) begin
          dime_n  = 1'b0;
          state_n = S_RELEASE;
        end else begin
          state_n = S_FAULT;
        end
      end
      S_RELEASE: begin
        if (cnt == PULSE_LAST) begin
          cnt_n   = '0;
          state_n = S_WAIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // A drop on the expiry cycle still wins over the timeout
        if (i_coin_drop) begin
          owed_n  = owed - (dime ? 3'd2 : 3'd1);
          cnt_n   = '0;
          state_n = S_GAP;
        end else if (cnt == TO_LAST) begin
          state_n = S_FAULT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = S_SELECT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_soda_rel   = (state == S_VEND);
  assign o_dime_rel   = (state == S_RELEASE) && dime;
  assign o_nickle_rel = (state == S_RELEASE) && !dime;
  assign o_busy       = (state != S_IDLE);
  assign o_fault      = (state == S_FAULT);
  assign o_owed       = owed;
  assign o_lost       = lost;

endmodule
